regfile_ng: RTL and testbench
=============================

# regfile_ng

Parametrised second-generation register file for the MIPS32 pipeline core. It provides configurable data width and register count, two asynchronous read ports with optional write-to-read bypass, and one synchronous write port. A per-register pending scoreboard lets the decode stage detect RAW hazards, and a sequential clear engine zeroes storage after reset or on request. It sits between the ID stage (reads, pending set) and the WB stage (writes).

## Interface
- DATA_W, 32, data width of each register
- NUM_REGS, 32, number of architectural registers (2..2^ADDR_W)
- ADDR_W, 5, register address width
- ZERO_REG, 1, 1 = register 0 hardwired to zero (never written, never pending)
- BYPASS, 1, 1 = same-cycle WB write forwarded to read ports and pending outputs

- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- read_reg1  in  ADDR_W  read port 1 address
- read_reg2  in  ADDR_W  read port 2 address
- id_reg1_data  out  DATA_W  port 1 data (combinational)
- id_reg2_data  out  DATA_W  port 2 data (combinational)
- id_reg1_pending  out  1  port 1 register has an outstanding write
- id_reg2_pending  out  1  port 2 register has an outstanding write
- wb_reg_write  in  1  write enable
- wb_rt_rd  in  ADDR_W  write address
- wb_write_data  in  DATA_W  write data
- id_pend_set  in  1  mark id_pend_addr pending (instruction issued with destination)
- id_pend_addr  in  ADDR_W  destination being marked
- clr_start  in  1  request full clear (sampled only in IDLE)
- busy  out  1  clear engine active; reads/writes not serviced

## Operation
- FSM states: CLEAR, IDLE. reset low at an edge -> CLEAR, clear index <= 0, all pending bits <= 0.
- CLEAR: each cycle with reset high writes 0 to register[index], index += 1; after writing NUM_REGS-1 -> IDLE. Writes, pend_set ignored; read data forced 0; pending outputs 0; busy = 1.
- IDLE: busy = 0. clr_start = 1 -> CLEAR, index <= 0, all pending bits cleared that edge; a write or pend_set in that same cycle is dropped.
- Write: in IDLE, wb_reg_write & valid address & !(ZERO_REG & addr==0) -> register[wb_rt_rd] <= wb_write_data at edge.
- Read: address 0 with ZERO_REG -> 0; address >= NUM_REGS -> 0; else register contents. BYPASS=1 and an accepted write to the same address this cycle -> wb_write_data.
- Pending: accepted write clears bit[wb_rt_rd]; id_pend_set sets bit[id_pend_addr] (ignored for zero reg / out of range). Same address set and clear in one cycle -> set wins.
- Pending outputs: bit[read addr]; BYPASS=1 and an accepted write to that address this cycle -> 0 unless the same-cycle pend_set targets it (then still reflects current bit).
- Out-of-range addresses (>= NUM_REGS): writes and pend_set ignored, reads 0, pending 0.

## Timing
- Reset values: busy = 1, id_reg*_data = 0, id_reg*_pending = 0, all pending bits 0; storage undefined until CLEAR completes.
- Clear latency: exactly NUM_REGS cycles with reset high from first CLEAR edge; busy falls after the edge writing NUM_REGS-1 (32 cycles at default).
- reset low mid-CLEAR restarts at index 0.
- Write latency: visible on reads next cycle without bypass, same cycle with BYPASS=1.
- Pending set visible on outputs the cycle after id_pend_set.
- Read paths purely combinational; no read latency.

## Test plan
- Reset low 2 cycles, release -> busy = 1 for 32 cycles, then 0; reads of r1..r31 all return 0.
- IDLE: write r5 = 0xDEADBEEF, read r5 same cycle -> 0xDEADBEEF (BYPASS=1), old value with BYPASS=0; next cycle 0xDEADBEEF either way.
- Write r0 = 0xFFFFFFFF with ZERO_REG=1 -> read r0 = 0; id_pend_set r0 -> pending stays 0.
- pend_set r7, next cycle read r7 -> pending = 1; WB write r7 = 0x12 -> pending 0 same cycle (BYPASS=1), data 0x12; same-cycle set+write on r7 -> pending 1 next cycle.
- clr_start with r3 = 0xA5A5A5A5 and r9 pending -> busy 32 cycles, writes in window dropped, afterwards r3 = 0, r9 not pending.
- NUM_REGS=16, ADDR_W=5: write addr 20 -> ignored; read addr 20 -> 0; clear completes in 16 cycles.

Source files
------------

// File: rtl/regfile_ng.sv
// regfile_ng: parametrised register file with two combinational read ports,
// one synchronous write port, optional write-to-read bypass, a per-register
// pending scoreboard for RAW hazard detection, and a sequential clear engine
// that zeroes storage after reset or on request.
module regfile_ng #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] read_reg1,
   input  logic [ADDR_W-1:0] read_reg2,
   output logic [DATA_W-1:0] id_reg1_data,
   output logic [DATA_W-1:0] id_reg2_data,
   output logic              id_reg1_pending,
   output logic              id_reg2_pending,
   input  logic              wb_reg_write,
   input  logic [ADDR_W-1:0] wb_rt_rd,
   input  logic [DATA_W-1:0] wb_write_data,
   input  logic              id_pend_set,
   input  logic [ADDR_W-1:0] id_pend_addr,
   input  logic              clr_start,
   output logic              busy
);

   // Storage spans the full address space so every address indexes cleanly;
   // entries at or above NUM_REGS are never written and fall away in synthesis.
   localparam int                DEPTH      = 1 << ADDR_W;
   localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);
   localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   state_t            state, state_next;
   logic [ADDR_W-1:0] clr_idx, clr_idx_next;
   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  pend;

   logic              idle;
   logic              wr_accept;
   logic              pset_accept;

   logic [ADDR_W-1:0] rd_addr [2];
   logic [DATA_W-1:0] rd_val  [2];
   logic              rd_pend [2];

   // An architectural register: in range and not the hardwired zero register.
   function automatic logic is_arch(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < NUM_REGS_W) && !(ZERO_REG && (a == '0));
   endfunction

   assign idle        = (state == ST_IDLE);
   assign busy        = !idle;
   // A clear request in IDLE takes precedence and drops same-cycle updates.
   assign wr_accept   = idle && !clr_start && wb_reg_write && is_arch(wb_rt_rd);
   assign pset_accept = idle && !clr_start && id_pend_set  && is_arch(id_pend_addr);

   assign rd_addr[0] = read_reg1;
   assign rd_addr[1] = read_reg2;

   // State register and clear index; reset restarts the clear sequence.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block evaluation order.
      if (!reset) begin
         state   <= ST_CLEAR;
         clr_idx <= '0;
      end else begin
         state   <= state_next;
         clr_idx <= clr_idx_next;
      end
   end

   // Next state: walk the clear index to NUM_REGS-1, or start a clear from IDLE.
   always_comb begin
      // NOTE: defaults first so every path assigns every output (no latches).
      state_next   = state;
      clr_idx_next = clr_idx;
      case (state)
         ST_CLEAR: begin
            if (clr_idx == LAST_IDX) state_next   = ST_IDLE;
            else                     clr_idx_next = clr_idx + 1'b1;
         end
         ST_IDLE: begin
            if (clr_start) begin
               state_next   = ST_CLEAR;
               clr_idx_next = '0;
            end
         end
         default: state_next = ST_CLEAR;
      endcase
   end

   // Storage: the clear engine zeroes one entry per cycle, otherwise WB writes.
   always_ff @(posedge clock) begin
      // NOTE: the array has no reset branch; the clear engine zeroes it, which
      // keeps it mappable to RAM and off the reset network.
      if (reset) begin
         if (!idle)          regs[clr_idx]  <= '0;
         else if (wr_accept) regs[wb_rt_rd] <= wb_write_data;
      end
   end

   // Pending scoreboard: write clears, issue sets; the later set wins on a tie.
   always_ff @(posedge clock) begin
      if (!reset) begin
         pend <= '0;
      end else if (idle && clr_start) begin
         pend <= '0;
      end else begin
         if (wr_accept)   pend[wb_rt_rd]     <= 1'b0;
         if (pset_accept) pend[id_pend_addr] <= 1'b1;
      end
   end

   // Read ports: zero while clearing or for non-architectural addresses,
   // with optional forwarding of the same-cycle WB write.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_val[p]  = '0;
         rd_pend[p] = 1'b0;
         if (idle && is_arch(rd_addr[p])) begin
            if (BYPASS && wr_accept && (wb_rt_rd == rd_addr[p])) begin
               rd_val[p]  = wb_write_data;
               rd_pend[p] = pset_accept && (id_pend_addr == rd_addr[p]) && pend[rd_addr[p]];
            end else begin
               rd_val[p]  = regs[rd_addr[p]];
               rd_pend[p] = pend[rd_addr[p]];
            end
         end
      end
   end

   assign id_reg1_data    = rd_val[0];
   assign id_reg2_data    = rd_val[1];
   assign id_reg1_pending = rd_pend[0];
   assign id_reg2_pending = rd_pend[1];

endmodule

// File: tb/tb_regfile_ng.sv
// tb_regfile_ng: drives three regfile_ng configurations (default, no bypass,
// 16 registers) with shared directed stimulus; a behavioural model is checked
// against all outputs every cycle, plus hand-computed literal expectations.
module tb_regfile_ng;

   logic        clock;
   logic        reset;
   logic [4:0]  read_reg1, read_reg2;
   logic        wb_reg_write;
   logic [4:0]  wb_rt_rd;
   logic [31:0] wb_write_data;
   logic        id_pend_set;
   logic [4:0]  id_pend_addr;
   logic        clr_start;

   logic [2:0][31:0] d1, d2;
   logic [2:0]       p1, p2, bsy;

   int n_checks = 0;
   int n_errors = 0;

   regfile_ng dut_def (
      .clock(clock), .reset(reset), .read_reg1(read_reg1), .read_reg2(read_reg2),
      .id_reg1_data(d1[0]), .id_reg2_data(d2[0]),
      .id_reg1_pending(p1[0]), .id_reg2_pending(p2[0]),
      .wb_reg_write(wb_reg_write), .wb_rt_rd(wb_rt_rd), .wb_write_data(wb_write_data),
      .id_pend_set(id_pend_set), .id_pend_addr(id_pend_addr),
      .clr_start(clr_start), .busy(bsy[0])
   );

   regfile_ng #(.BYPASS(1'b0)) dut_nb (
      .clock(clock), .reset(reset), .read_reg1(read_reg1), .read_reg2(read_reg2),
      .id_reg1_data(d1[1]), .id_reg2_data(d2[1]),
      .id_reg1_pending(p1[1]), .id_reg2_pending(p2[1]),
      .wb_reg_write(wb_reg_write), .wb_rt_rd(wb_rt_rd), .wb_write_data(wb_write_data),
      .id_pend_set(id_pend_set), .id_pend_addr(id_pend_addr),
      .clr_start(clr_start), .busy(bsy[1])
   );

   regfile_ng #(.NUM_REGS(16)) dut_16 (
      .clock(clock), .reset(reset), .read_reg1(read_reg1), .read_reg2(read_reg2),
      .id_reg1_data(d1[2]), .id_reg2_data(d2[2]),
      .id_reg1_pending(p1[2]), .id_reg2_pending(p2[2]),
      .wb_reg_write(wb_reg_write), .wb_rt_rd(wb_rt_rd), .wb_write_data(wb_write_data),
      .id_pend_set(id_pend_set), .id_pend_addr(id_pend_addr),
      .clr_start(clr_start), .busy(bsy[2])
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          nr  [3] = '{32, 32, 16};
   bit          byp [3] = '{1'b1, 1'b0, 1'b1};
   logic [31:0] m_regs  [3][32];
   bit          m_known [3][32];
   bit          m_pend  [3][32];
   bit          m_clr   [3];
   int          m_idx   [3];
   bit          m_valid = 1'b0;

   function automatic bit arch(input int c, input int a);
      return (a != 0) && (a < nr[c]);
   endfunction

   task automatic model_step();
      for (int c = 0; c < 3; c++) begin
         if (!reset) begin
            m_clr[c] = 1'b1;
            m_idx[c] = 0;
            for (int i = 0; i < 32; i++) begin
               m_pend[c][i]  = 1'b0;
               m_known[c][i] = 1'b0;
            end
         end else if (m_clr[c]) begin
            m_regs[c][m_idx[c]]  = 32'h0;
            m_known[c][m_idx[c]] = 1'b1;
            m_idx[c]++;
            if (m_idx[c] == nr[c]) m_clr[c] = 1'b0;
         end else if (clr_start) begin
            m_clr[c] = 1'b1;
            m_idx[c] = 0;
            for (int i = 0; i < 32; i++) m_pend[c][i] = 1'b0;
         end else begin
            if (wb_reg_write && arch(c, int'(wb_rt_rd))) begin
               m_regs[c][wb_rt_rd]  = wb_write_data;
               m_known[c][wb_rt_rd] = 1'b1;
               m_pend[c][wb_rt_rd]  = 1'b0;
            end
            if (id_pend_set && arch(c, int'(id_pend_addr))) m_pend[c][id_pend_addr] = 1'b1;
         end
      end
      if (!reset) m_valid = 1'b1;
   endtask

   task automatic compare_port(input int c, input int p, input int a,
                               input logic [31:0] act_d, input logic act_p);
      bit wacc, pacc;
      wacc = wb_reg_write && !clr_start && arch(c, int'(wb_rt_rd));
      pacc = id_pend_set  && !clr_start && arch(c, int'(id_pend_addr));
      if (m_clr[c] || !arch(c, a)) begin
         check($sformatf("cfg%0d port%0d data a%0d", c, p, a), 64'(act_d), 64'h0);
         check($sformatf("cfg%0d port%0d pend a%0d", c, p, a), 64'(act_p), 64'h0);
      end else begin
         if (byp[c] && wacc && (int'(wb_rt_rd) == a))
            check($sformatf("cfg%0d port%0d data a%0d", c, p, a), 64'(act_d), 64'(wb_write_data));
         else if (m_known[c][a])
            check($sformatf("cfg%0d port%0d data a%0d", c, p, a), 64'(act_d), 64'(m_regs[c][a]));
         if (byp[c] && wacc && (int'(wb_rt_rd) == a) && !(pacc && (int'(id_pend_addr) == a)))
            check($sformatf("cfg%0d port%0d pend a%0d", c, p, a), 64'(act_p), 64'h0);
         else
            check($sformatf("cfg%0d port%0d pend a%0d", c, p, a), 64'(act_p), 64'(m_pend[c][a]));
      end
   endtask

   initial forever begin
      @(posedge clock);
      model_step();
   end

   initial forever begin
      @(negedge clock);
      if (m_valid) begin
         for (int c = 0; c < 3; c++) begin
            check($sformatf("cfg%0d busy", c), 64'(bsy[c]), 64'(m_clr[c]));
            compare_port(c, 1, int'(read_reg1), d1[c], p1[c]);
            compare_port(c, 2, int'(read_reg2), d2[c], p2[c]);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic next();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_in();
      wb_reg_write = 1'b0;
      id_pend_set  = 1'b0;
      clr_start    = 1'b0;
   endtask

   // Counts busy cycles per instance; stimulus writes are dropped after stop_at.
   task automatic count_busy(input int stop_at, output int c0, output int c1, output int c2);
      c0 = 0; c1 = 0; c2 = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clock);
         if (bsy == 3'b000) break;
         c0 += int'(bsy[0]);
         c1 += int'(bsy[1]);
         c2 += int'(bsy[2]);
         next();
         if (k == stop_at) idle_in();
      end
      check("clear engine finished", 64'(bsy), 64'h0);
   endtask

   int c0, c1, c2;

   initial begin
      reset = 1'b0; idle_in();
      read_reg1 = 5'd1; read_reg2 = 5'd2;
      wb_rt_rd = '0; wb_write_data = '0; id_pend_addr = '0;

      // Reset state, two reset edges, then release.
      @(posedge clock);
      @(negedge clock);
      check("reset busy",  64'(bsy), 64'h7);
      check("reset data1", 64'(d1[0]), 64'h0);
      check("reset pend1", 64'(p1[0]), 64'h0);
      next();
      reset = 1'b1;
      count_busy(-1, c0, c1, c2);
      check("clear cycles cfg0", 64'(c0), 64'd32);
      check("clear cycles cfg1", 64'(c1), 64'd32);
      check("clear cycles cfg2", 64'(c2), 64'd16);
      next();

      // Every register reads zero after the clear.
      for (int a = 1; a < 32; a++) begin
         read_reg1 = 5'(a);
         read_reg2 = 5'(32 - a);
         @(negedge clock);
         check($sformatf("cleared r%0d", a), 64'(d1[0]), 64'h0);
         next();
      end

      // Write r5: same-cycle bypass vs. old value, then visible everywhere.
      wb_reg_write = 1'b1; wb_rt_rd = 5'd5; wb_write_data = 32'hDEADBEEF; read_reg1 = 5'd5;
      @(negedge clock);
      check("r5 bypass",    64'(d1[0]), 64'hDEADBEEF);
      check("r5 no bypass", 64'(d1[1]), 64'h0);
      next(); idle_in();
      @(negedge clock);
      check("r5 next cfg0", 64'(d1[0]), 64'hDEADBEEF);
      check("r5 next cfg1", 64'(d1[1]), 64'hDEADBEEF);
      next();

      // Zero register: never written, never pending.
      wb_reg_write = 1'b1; wb_rt_rd = 5'd0; wb_write_data = 32'hFFFFFFFF;
      read_reg1 = 5'd0; read_reg2 = 5'd0;
      @(negedge clock);
      check("r0 write bypass", 64'(d1[0]), 64'h0);
      next(); idle_in();
      id_pend_set = 1'b1; id_pend_addr = 5'd0;
      next(); idle_in();
      @(negedge clock);
      check("r0 data",    64'(d1[0]), 64'h0);
      check("r0 pending", 64'(p1[0]), 64'h0);
      next();

      // Pending set / write clear / simultaneous set+write on r7.
      read_reg1 = 5'd7; id_pend_set = 1'b1; id_pend_addr = 5'd7;
      @(negedge clock);
      check("r7 pend set cycle", 64'(p1[0]), 64'h0);
      next(); idle_in();
      @(negedge clock);
      check("r7 pend next", 64'(p1[0]), 64'h1);
      next();
      wb_reg_write = 1'b1; wb_rt_rd = 5'd7; wb_write_data = 32'h12;
      @(negedge clock);
      check("r7 wb data",        64'(d1[0]), 64'h12);
      check("r7 wb pend bypass", 64'(p1[0]), 64'h0);
      check("r7 wb pend nobyp",  64'(p1[1]), 64'h1);
      next();
      wb_write_data = 32'h34; id_pend_set = 1'b1; id_pend_addr = 5'd7;
      @(negedge clock);
      check("r7 set+wb data", 64'(d1[0]), 64'h34);
      check("r7 set+wb pend", 64'(p1[0]), 64'h0);
      next(); idle_in();
      @(negedge clock);
      check("r7 set wins cfg0", 64'(p1[0]), 64'h1);
      check("r7 set wins cfg1", 64'(p1[1]), 64'h1);
      next();

      // Clear on request with live state and writes inside the window.
      wb_reg_write = 1'b1; wb_rt_rd = 5'd3; wb_write_data = 32'hA5A5A5A5;
      id_pend_set = 1'b1; id_pend_addr = 5'd9;
      next(); idle_in();
      read_reg1 = 5'd3; read_reg2 = 5'd9;
      @(negedge clock);
      check("r3 before clear", 64'(d1[0]), 64'hA5A5A5A5);
      check("r9 before clear", 64'(p2[0]), 64'h1);
      next();
      clr_start = 1'b1; wb_reg_write = 1'b1; wb_rt_rd = 5'd4; wb_write_data = 32'h77;
      read_reg1 = 5'd4;
      @(negedge clock);
      check("clr cycle write dropped", 64'(d1[0]), 64'h0);
      next();
      clr_start = 1'b0; wb_rt_rd = 5'd3; wb_write_data = 32'h11;
      id_pend_set = 1'b1; id_pend_addr = 5'd9; read_reg1 = 5'd3;
      count_busy(9, c0, c1, c2);
      check("req clear cycles cfg0", 64'(c0), 64'd32);
      check("req clear cycles cfg2", 64'(c2), 64'd16);
      check("r3 after clear",  64'(d1[0]), 64'h0);
      check("r9 after clear",  64'(p2[0]), 64'h0);
      next();
      read_reg1 = 5'd4;
      @(negedge clock);
      check("r4 after clear", 64'(d1[0]), 64'h0);
      next();

      // Out-of-range address on the 16-register instance.
      wb_reg_write = 1'b1; wb_rt_rd = 5'd20; wb_write_data = 32'h99;
      read_reg1 = 5'd20; read_reg2 = 5'd31;
      @(negedge clock);
      check("a20 cfg2 bypass", 64'(d1[2]), 64'h0);
      check("a20 cfg0 bypass", 64'(d1[0]), 64'h99);
      next(); idle_in();
      id_pend_set = 1'b1; id_pend_addr = 5'd20;
      @(negedge clock);
      check("a20 cfg2 read", 64'(d1[2]), 64'h0);
      check("a31 cfg2 read", 64'(d2[2]), 64'h0);
      next(); idle_in();
      @(negedge clock);
      check("a20 cfg2 pend", 64'(p1[2]), 64'h0);
      check("a20 cfg0 pend", 64'(p1[0]), 64'h1);
      next();

      // Reset in the middle of a clear restarts it from index 0.
      clr_start = 1'b1;
      next(); idle_in();
      repeat (5) next();
      reset = 1'b0;
      next();
      reset = 1'b1;
      count_busy(-1, c0, c1, c2);
      check("restart clear cfg0", 64'(c0), 64'd32);
      check("restart clear cfg2", 64'(c2), 64'd16);
      next();
      read_reg1 = 5'd5; read_reg2 = 5'd7;
      @(negedge clock);
      check("r5 after restart", 64'(d1[0]), 64'h0);
      check("r7 pend after restart", 64'(p2[0]), 64'h0);
      next();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
